// File: rtl/mac_rx_sync_fifo.sv
// rtl/mac_rx_sync_fifo.sv - single-clock receive FIFO with level, thresholds, sticky errors and flush
module mac_rx_sync_fifo #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_SIZE  = 8,
    parameter int AFULL_TH   = 250,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  I_flush,
    input  logic                  I_clr_err,
    input  logic                  IEN_wr,
    input  logic [DATA_WIDTH-1:0] I_data,
    input  logic                  IEN_rd,
    output logic [DATA_WIDTH-1:0] O_data,
    output logic                  O_valid,
    output logic                  OFIFO_full,
    output logic                  OFIFO_empty,
    output logic                  OFIFO_afull,
    output logic                  OFIFO_aempty,
    output logic [ADDR_SIZE:0]    O_level,
    output logic                  O_overflow,
    output logic                  O_underflow
);

    localparam int                 DEPTH     = 1 << ADDR_SIZE;
    localparam int                 LW        = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [ADDR_SIZE:0] LVL_AFULL = LW'(AFULL_TH);
    localparam logic [ADDR_SIZE:0] LVL_AEMPT = LW'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;

    logic rd_acc;
    logic wr_acc;
    logic rd_en;
    logic wr_en;
    logic ovf_set;
    logic unf_set;

    assign OFIFO_full   = (O_level == LVL_FULL);
    assign OFIFO_empty  = (O_level == '0);
    assign OFIFO_afull  = (O_level >= LVL_AFULL);
    assign OFIFO_aempty = (O_level <= LVL_AEMPT);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = IEN_rd & ~OFIFO_empty;
    assign wr_acc = IEN_wr & (~OFIFO_full | rd_acc);

    // Flush cancels both requests and leaves the error flags alone.
    assign rd_en   = rd_acc & ~I_flush;
    assign wr_en   = wr_acc & ~I_flush;
    assign ovf_set = IEN_wr & ~wr_acc & ~I_flush;
    assign unf_set = IEN_rd & OFIFO_empty & ~I_flush;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= I_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            O_level     <= '0;
            O_data      <= '0;
            O_valid     <= 1'b0;
            O_overflow  <= 1'b0;
            O_underflow <= 1'b0;
        end else if (I_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            O_level <= '0;
            O_valid <= 1'b0;
        end else begin
            O_valid <= rd_en;
            if (rd_en) begin
                O_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            O_level <= O_level + LW'(wr_en) - LW'(rd_en);

            if (ovf_set) begin
                O_overflow <= 1'b1;
            end else if (I_clr_err) begin
                O_overflow <= 1'b0;
            end

            if (unf_set) begin
                O_underflow <= 1'b1;
            end else if (I_clr_err) begin
                O_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_sync_fifo.sv
// tb/tb_mac_rx_sync_fifo.sv - directed self-checking bench for mac_rx_sync_fifo
module tb_mac_rx_sync_fifo;

    localparam int DW    = 8;
    localparam int AS    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          I_flush;
    logic          I_clr_err;
    logic          IEN_wr;
    logic [DW-1:0] I_data;
    logic          IEN_rd;
    logic [DW-1:0] O_data;
    logic          O_valid;
    logic          OFIFO_full;
    logic          OFIFO_empty;
    logic          OFIFO_afull;
    logic          OFIFO_aempty;
    logic [AS:0]   O_level;
    logic          O_overflow;
    logic          O_underflow;

    int n_tests;
    int n_fail;
    logic [DW-1:0] q [$];
    logic [DW-1:0] last_rd;

    mac_rx_sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_SIZE  (AS),
        .AFULL_TH   (6),
        .AEMPTY_TH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .I_flush      (I_flush),
        .I_clr_err    (I_clr_err),
        .IEN_wr       (IEN_wr),
        .I_data       (I_data),
        .IEN_rd       (IEN_rd),
        .O_data       (O_data),
        .O_valid      (O_valid),
        .OFIFO_full   (OFIFO_full),
        .OFIFO_empty  (OFIFO_empty),
        .OFIFO_afull  (OFIFO_afull),
        .OFIFO_aempty (OFIFO_aempty),
        .O_level      (O_level),
        .O_overflow   (O_overflow),
        .O_underflow  (O_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic against the reference queue; checks read data, strobe and level.
    task automatic cycle(input logic wr, input logic [DW-1:0] wd, input logic rd);
        bit rd_ok;
        bit wr_ok;
        logic [DW-1:0] exp;
        rd_ok  = rd && (q.size() > 0);
        wr_ok  = wr && ((q.size() < DEPTH) || rd_ok);
        IEN_wr = wr;
        I_data = wd;
        IEN_rd = rd;
        step();
        IEN_wr = 1'b0;
        IEN_rd = 1'b0;
        if (rd_ok) begin
            exp     = q.pop_front();
            last_rd = exp;
            check("rd_valid", O_valid, 1);
            check("rd_data", O_data, exp);
        end else begin
            check("no_valid", O_valid, 0);
        end
        if (wr_ok) q.push_back(wd);
        check("level", O_level, q.size());
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        last_rd   = '0;
        rst       = 1'b1;
        I_flush   = 1'b0;
        I_clr_err = 1'b0;
        IEN_wr    = 1'b1;
        I_data    = 8'h5a;
        IEN_rd    = 1'b0;

        // Reset holds despite a pending write
        step();
        step();
        rst    = 1'b0;
        IEN_wr = 1'b0;
        check("rst_level", O_level, 0);
        check("rst_empty", OFIFO_empty, 1);
        check("rst_aempty", OFIFO_aempty, 1);
        check("rst_full", OFIFO_full, 0);
        check("rst_afull", OFIFO_afull, 0);
        check("rst_valid", O_valid, 0);
        check("rst_data", O_data, 0);
        check("rst_ovf", O_overflow, 0);
        check("rst_unf", O_underflow, 0);

        // Ordering
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        check("order_last", last_rd, 3);
        step();
        check("idle_valid", O_valid, 0);
        check("hold_data", O_data, 3);
        check("order_empty", OFIFO_empty, 1);

        // Fill to full, ninth write dropped
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0);
            if (i == 7) begin
                check("full_at8", OFIFO_full, 1);
                check("ovf_before", O_overflow, 0);
            end
        end
        check("full_level", O_level, 8);
        check("ovf_set", O_overflow, 1);
        check("full_afull", OFIFO_afull, 1);
        I_clr_err = 1'b1;
        step();
        I_clr_err = 1'b0;
        check("ovf_clr", O_overflow, 0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        check("drain_last", last_rd, 8'h17);

        // Full with simultaneous read+write across pointer wrap
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1);
        check("simul_level", O_level, 8);
        check("simul_full", OFIFO_full, 1);
        check("simul_ovf", O_overflow, 0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        check("wrap_last", last_rd, 8'h43);

        // Underflow, clear, and set-wins-over-clear
        cycle(1'b0, 8'h00, 1'b1);
        check("unf_set", O_underflow, 1);
        I_clr_err = 1'b1;
        step();
        I_clr_err = 1'b0;
        check("unf_clr", O_underflow, 0);
        I_clr_err = 1'b1;
        IEN_rd    = 1'b1;
        step();
        I_clr_err = 1'b0;
        IEN_rd    = 1'b0;
        check("unf_setwins", O_underflow, 1);
        check("unf_novalid", O_valid, 0);

        // Empty + write + read: write only, no fall-through
        cycle(1'b1, 8'h77, 1'b1);
        check("ewr_unf", O_underflow, 1);
        check("ewr_level", O_level, 1);
        cycle(1'b0, 8'h00, 1'b1);
        check("ewr_data", O_data, 8'h77);

        // Thresholds
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'(8'h50 + i), 1'b0);
            check("afull_th", OFIFO_afull, (i + 1) >= 6);
            check("aempty_th", OFIFO_aempty, (i + 1) <= 2);
        end

        // Flush ignores the write requested in the same cycle
        I_flush = 1'b1;
        IEN_wr  = 1'b1;
        I_data  = 8'h99;
        IEN_rd  = 1'b1;
        step();
        I_flush = 1'b0;
        IEN_wr  = 1'b0;
        IEN_rd  = 1'b0;
        q.delete();
        check("fl_level", O_level, 0);
        check("fl_empty", OFIFO_empty, 1);
        check("fl_aempty", OFIFO_aempty, 1);
        check("fl_afull", OFIFO_afull, 0);
        check("fl_valid", O_valid, 0);
        check("fl_hold", O_data, 8'h77);
        check("fl_unf", O_underflow, 1);
        cycle(1'b1, 8'h60, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("fl_next", O_data, 8'h60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
